acl2_poll_scheduler: RTL
========================

Name: acl2_poll_scheduler

Overview:
Sequences the SPI transaction engine that talks to the ADXL362 on the Pmod ACL2. After reset it waits out power-up, soft-resets the part, checks DEVID_AD and enables measurement mode. It then sweeps the X/Y/Z 8-bit data registers at a fixed rate and publishes one coherent sample set per sweep. It sits between the transaction engine and the display/consumer logic, and replaces manual switch/button sequencing.

Parameters:
STARTUP_CYCLES, 625000, wait after reset before the first transaction (5 ms at 125 MHz)
SRESET_CYCLES, 62500, wait after the soft-reset write (0.5 ms)
POLL_CYCLES, 1250000, sweep period measured start-to-start (100 Hz)
TIMEOUT_CYCLES, 250000, maximum cycles from accept to TXN_DONE
MAX_RETRIES, 3, consecutive DEVID mismatches tolerated before a sticky ERROR

Ports:
CLK  in  1  125 MHz system clock
RST  in  1  synchronous reset, active-high
ENABLE  in  1  1 = run polling; 0 = finish current transaction then park in HOLD
TXN_VALID  out  1  request to the transaction engine
TXN_READY  in  1  engine can accept; transfer happens when TXN_VALID && TXN_READY
TXN_INSTR  out  8  0x0A write, 0x0B register read
TXN_ADDR  out  8  register address
TXN_WDATA  out  8  write data; 0 for reads
TXN_DONE  in  1  one-cycle pulse, transaction complete
TXN_RDATA  in  8  read data; valid when TXN_DONE = 1
X_DATA, Y_DATA, Z_DATA  out  8 each  latest coherent sample set
SAMPLE_VALID  out  1  one-cycle pulse when X/Y/Z are updated
BUSY  out  1  high in every state except HOLD and FAULT
ERROR  out  1  sticky; cleared only by RST

Behaviour:
- Reset values: TXN_VALID=0, TXN_INSTR/ADDR/WDATA=0, X/Y/Z_DATA=0, SAMPLE_VALID=0, ERROR=0, BUSY=1, retry count=0. State = STARTUP with the wait counter cleared.
- RST is synchronous and overrides everything, including mid-transaction. Any TXN_DONE that arrives after reset is ignored.
- Handshake:
  - TXN_VALID rises together with stable INSTR/ADDR/WDATA.
  - All four are held until the cycle where TXN_READY=1; TXN_VALID drops on the next cycle.
  - The block then waits for TXN_DONE and issues no new request until it arrives.
  - A TXN_DONE with no outstanding request is ignored.
- Timeout: a counter runs from accept. If it reaches TIMEOUT_CYCLES without TXN_DONE, ERROR is set, the state goes to SRESET_WR, and retry count is not affected.
- States and transitions:
  - STARTUP: count STARTUP_CYCLES, then go to SRESET_WR.
  - SRESET_WR: write 0x1F=0x52. On DONE go to SRESET_WAIT.
  - SRESET_WAIT: count SRESET_CYCLES, then go to ID_RD.
  - ID_RD: read 0x00.
    - DONE with RDATA=0xAD: clear retry count, go to CFG_WR.
    - Any other value: increment retry count. If the count reaches MAX_RETRIES, set ERROR and go to FAULT; otherwise go to SRESET_WR.
  - CFG_WR: write 0x2D=0x02 (measurement mode). On DONE go to POLL_X.
  - POLL_X / POLL_Y / POLL_Z: read 0x08 / 0x09 / 0x0A, capturing each result into a shadow register.
  - On the POLL_Z DONE:
    - X/Y/Z_DATA load from the shadows, with Z taken directly from TXN_RDATA, all in the same cycle.
    - SAMPLE_VALID pulses on the next cycle.
    - State goes to POLL_WAIT.
  - POLL_WAIT: leave when the period counter (started at the POLL_X request) reaches POLL_CYCLES, or immediately if the sweep overran. Go to POLL_X if ENABLE=1, otherwise HOLD.
  - HOLD: TXN_VALID=0, BUSY=0. When ENABLE=1, go to POLL_X on the next cycle.
  - FAULT: terminal until RST; TXN_VALID=0, BUSY=0.
- ENABLE is sampled only in POLL_WAIT and HOLD. Dropping it mid-sweep completes the sweep, so outputs always form a coherent set.
- X/Y/Z hold their values through HOLD, FAULT and the re-init that follows a timeout. No partial sweep is ever published.
- The period counter saturates at POLL_CYCLES and never wraps. Counter widths are $clog2 of the largest parameter + 1.

Decomposition:
- Package acl2_pkg holds:
  - Instruction constants: INSTR_WRITE=0x0A, INSTR_READ=0x0B, INSTR_FIFO=0x0D.
  - Register addresses: DEVID_AD=0x00, XDATA=0x08, YDATA=0x09, ZDATA=0x0A, SOFT_RESET=0x1F, POWER_CTL=0x2D.
  - Values: RESET_KEY=0x52, MEAS_MODE=0x02, DEVID_VAL=0xAD.
  - State enum typedef.
- One sub-module, acl2_delay_counter (load/count/done), is instantiated for the startup/sreset wait, the poll period and the timeout.

Test Plan:
- Setup: parameters 20/10/200/50/3, ENABLE=1, engine model with READY=1 and DONE 5 cycles after accept, DEVID=0xAD, X/Y/Z=0x11/0x22/0x33 -> transaction order (0x0A,0x1F,0x52), (0x0B,0x00), (0x0A,0x2D,0x02), (0x0B,0x08), (0x0B,0x09), (0x0B,0x0A); SAMPLE_VALID pulses once with X/Y/Z=0x11/0x22/0x33; next POLL_X request exactly 200 cycles after the previous one.
- Model returns DEVID 0x00 always -> exactly 3 soft-reset/ID cycles, then ERROR=1, BUSY=0, no further TXN_VALID.
- Model never pulses DONE on the POLL_Y read -> ERROR=1 exactly 50 cycles after accept, next request is (0x0A,0x1F,0x52), X/Y/Z unchanged.
- READY held 0 for 30 cycles during CFG_WR -> TXN_VALID and fields stable for all 30 cycles, single transfer, no timeout.
- ENABLE dropped during POLL_Y -> POLL_Z completes, SAMPLE_VALID pulses, then HOLD with BUSY=0. Re-assert ENABLE -> POLL_X request within 2 cycles.
- RST asserted 2 cycles after a POLL_X accept, with a late DONE arriving afterwards -> all outputs return to reset values, the late DONE is ignored, and the sequence restarts at STARTUP.

Source files
------------

// File: rtl/acl2_pkg.sv
// ADXL362 (Pmod ACL2) register map, SPI instruction codes and scheduler
// state encoding, shared by the poll scheduler and its testbench.
`timescale 1ns/1ps
package acl2_pkg;

  // SPI instruction bytes
  localparam logic [7:0] INSTR_WRITE = 8'h0A;
  localparam logic [7:0] INSTR_READ  = 8'h0B;
  localparam logic [7:0] INSTR_FIFO  = 8'h0D;

  // Register addresses
  localparam logic [7:0] DEVID_AD   = 8'h00;
  localparam logic [7:0] XDATA      = 8'h08;
  localparam logic [7:0] YDATA      = 8'h09;
  localparam logic [7:0] ZDATA      = 8'h0A;
  localparam logic [7:0] SOFT_RESET = 8'h1F;
  localparam logic [7:0] POWER_CTL  = 8'h2D;

  // Register values
  localparam logic [7:0] RESET_KEY = 8'h52;
  localparam logic [7:0] MEAS_MODE = 8'h02;
  localparam logic [7:0] DEVID_VAL = 8'hAD;

  typedef enum logic [3:0] {
    ST_STARTUP,
    ST_SRESET_WR,
    ST_SRESET_WAIT,
    ST_ID_RD,
    ST_CFG_WR,
    ST_POLL_X,
    ST_POLL_Y,
    ST_POLL_Z,
    ST_POLL_WAIT,
    ST_HOLD,
    ST_FAULT
  } state_e;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_req_t;

  // States that own exactly one SPI transaction
  function automatic logic is_txn_state(input state_e s);
    return (s inside {ST_SRESET_WR, ST_ID_RD, ST_CFG_WR,
                      ST_POLL_X, ST_POLL_Y, ST_POLL_Z});
  endfunction

  // Request issued on entry to a transaction state
  function automatic txn_req_t txn_for(input state_e s);
    txn_req_t r;
    r = '0;
    case (s)
      ST_SRESET_WR: r = '{INSTR_WRITE, SOFT_RESET, RESET_KEY};
      ST_ID_RD:     r = '{INSTR_READ,  DEVID_AD,   8'h00};
      ST_CFG_WR:    r = '{INSTR_WRITE, POWER_CTL,  MEAS_MODE};
      ST_POLL_X:    r = '{INSTR_READ,  XDATA,      8'h00};
      ST_POLL_Y:    r = '{INSTR_READ,  YDATA,      8'h00};
      ST_POLL_Z:    r = '{INSTR_READ,  ZDATA,      8'h00};
      default:      r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/acl2_delay_counter.sv
// Saturating cycle counter.
//   load  : restart; the load cycle itself counts as the first elapsed cycle
//   en    : advance by one per cycle until limit is reached
//   limit : terminal count (may change between loads)
//   done  : count has reached limit; a transition taken on done therefore
//           lands exactly `limit` cycles after the load edge
`timescale 1ns/1ps
module acl2_delay_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt;

  assign done = (cnt >= limit);

  always_ff @(posedge CLK) begin
    if (RST)              cnt <= '0;
    else if (load)        cnt <= W'(1);
    else if (en && !done) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/acl2_poll_scheduler.sv
// ADXL362 bring-up and X/Y/Z polling sequencer in front of an SPI
// transaction engine.
//   CLK, RST (sync, active-high), ENABLE (run / park in HOLD)
//   TXN_VALID/READY/INSTR/ADDR/WDATA : request handshake to the engine
//   TXN_DONE/RDATA                   : completion pulse and read data
//   X/Y/Z_DATA, SAMPLE_VALID         : coherent sample set + update pulse
//   BUSY (not HOLD/FAULT), ERROR (sticky until RST)
`timescale 1ns/1ps
module acl2_poll_scheduler
  import acl2_pkg::*;
#(
  parameter int STARTUP_CYCLES = 625000,
  parameter int SRESET_CYCLES  = 62500,
  parameter int POLL_CYCLES    = 1250000,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  output logic       TXN_VALID,
  input  logic       TXN_READY,
  output logic [7:0] TXN_INSTR,
  output logic [7:0] TXN_ADDR,
  output logic [7:0] TXN_WDATA,
  input  logic       TXN_DONE,
  input  logic [7:0] TXN_RDATA,
  output logic [7:0] X_DATA,
  output logic [7:0] Y_DATA,
  output logic [7:0] Z_DATA,
  output logic       SAMPLE_VALID,
  output logic       BUSY,
  output logic       ERROR
);

  localparam int MAX_A = (STARTUP_CYCLES > SRESET_CYCLES)  ? STARTUP_CYCLES : SRESET_CYCLES;
  localparam int MAX_B = (POLL_CYCLES    > TIMEOUT_CYCLES) ? POLL_CYCLES    : TIMEOUT_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P) + 1;
  localparam int RW    = $clog2(MAX_RETRIES + 1);

  state_e         state, state_n;
  txn_req_t       req_q;
  logic           outstanding;
  logic [7:0]     x_sh, y_sh;
  logic [RW-1:0]  retry_cnt, retry_nxt;

  logic go, accept, done_evt, tmo_evt, set_err, retry_clr, retry_inc;
  logic wait_done, per_done, tmo_done;
  logic [CW-1:0] wait_lim;

  assign accept    = TXN_VALID && TXN_READY;
  // DONE only counts while a request is in flight; stray or post-reset
  // pulses fall through here.
  assign done_evt  = outstanding && TXN_DONE;
  assign retry_nxt = retry_cnt + RW'(1);
  assign BUSY      = !(state == ST_HOLD || state == ST_FAULT);

  assign TXN_INSTR = req_q.instr;
  assign TXN_ADDR  = req_q.addr;
  assign TXN_WDATA = req_q.wdata;

  // One counter serves both fixed waits; they never overlap.
  assign wait_lim = (state == ST_STARTUP) ? CW'(STARTUP_CYCLES) : CW'(SRESET_CYCLES);

  acl2_delay_counter #(.W(CW)) u_wait (
    .CLK   (CLK),
    .RST   (RST),
    .load  (go && state_n == ST_SRESET_WAIT),
    .en    (state == ST_STARTUP || state == ST_SRESET_WAIT),
    .limit (wait_lim),
    .done  (wait_done)
  );

  // Sweep period, start-to-start from the POLL_X request. Runs free and
  // saturates, so an overrunning sweep finds it already done.
  acl2_delay_counter #(.W(CW)) u_period (
    .CLK   (CLK),
    .RST   (RST),
    .load  (go && state_n == ST_POLL_X),
    .en    (1'b1),
    .limit (CW'(POLL_CYCLES)),
    .done  (per_done)
  );

  acl2_delay_counter #(.W(CW)) u_timeout (
    .CLK   (CLK),
    .RST   (RST),
    .load  (accept),
    .en    (outstanding),
    .limit (CW'(TIMEOUT_CYCLES)),
    .done  (tmo_done)
  );

  always_comb begin
    state_n   = state;
    go        = 1'b0;
    set_err   = 1'b0;
    tmo_evt   = 1'b0;
    retry_clr = 1'b0;
    retry_inc = 1'b0;
    case (state)
      ST_STARTUP:     if (wait_done) begin state_n = ST_SRESET_WR;   go = 1'b1; end
      ST_SRESET_WR:   if (done_evt)  begin state_n = ST_SRESET_WAIT; go = 1'b1; end
      ST_SRESET_WAIT: if (wait_done) begin state_n = ST_ID_RD;       go = 1'b1; end
      ST_ID_RD: begin
        if (done_evt) begin
          go = 1'b1;
          if (TXN_RDATA == DEVID_VAL) begin
            retry_clr = 1'b1;
            state_n   = ST_CFG_WR;
          end else begin
            retry_inc = 1'b1;
            if (retry_nxt >= RW'(MAX_RETRIES)) begin
              set_err = 1'b1;
              state_n = ST_FAULT;
            end else begin
              state_n = ST_SRESET_WR;
            end
          end
        end
      end
      ST_CFG_WR:      if (done_evt)  begin state_n = ST_POLL_X;    go = 1'b1; end
      ST_POLL_X:      if (done_evt)  begin state_n = ST_POLL_Y;    go = 1'b1; end
      ST_POLL_Y:      if (done_evt)  begin state_n = ST_POLL_Z;    go = 1'b1; end
      ST_POLL_Z:      if (done_evt)  begin state_n = ST_POLL_WAIT; go = 1'b1; end
      ST_POLL_WAIT: begin
        if (per_done) begin
          go      = 1'b1;
          state_n = ENABLE ? ST_POLL_X : ST_HOLD;
        end
      end
      ST_HOLD:        if (ENABLE)    begin state_n = ST_POLL_X;    go = 1'b1; end
      default: ;
    endcase
    // A late DONE in the same cycle as expiry still wins.
    if (outstanding && !TXN_DONE && tmo_done) begin
      state_n = ST_SRESET_WR;
      go      = 1'b1;
      set_err = 1'b1;
      tmo_evt = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_STARTUP;
      req_q        <= '0;
      TXN_VALID    <= 1'b0;
      outstanding  <= 1'b0;
      x_sh         <= '0;
      y_sh         <= '0;
      X_DATA       <= '0;
      Y_DATA       <= '0;
      Z_DATA       <= '0;
      SAMPLE_VALID <= 1'b0;
      ERROR        <= 1'b0;
      retry_cnt    <= '0;
    end else begin
      state        <= state_n;
      SAMPLE_VALID <= 1'b0;
      if (accept) begin
        TXN_VALID   <= 1'b0;
        outstanding <= 1'b1;
      end
      if (done_evt || tmo_evt) outstanding <= 1'b0;
      // Request fields change only here, together with VALID rising.
      if (go && is_txn_state(state_n)) begin
        TXN_VALID <= 1'b1;
        req_q     <= txn_for(state_n);
      end
      if (set_err) ERROR <= 1'b1;
      if (retry_clr)      retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_nxt;
      if (done_evt) begin
        case (state)
          ST_POLL_X: x_sh <= TXN_RDATA;
          ST_POLL_Y: y_sh <= TXN_RDATA;
          ST_POLL_Z: begin
            // Publish the whole set at once; Z bypasses its shadow.
            X_DATA       <= x_sh;
            Y_DATA       <= y_sh;
            Z_DATA       <= TXN_RDATA;
            SAMPLE_VALID <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
